// File: rtl/rdm_dpsram_ctrl.sv
// ============================================================================
// rdm_dpsram_ctrl: zero-fill, round-robin write arbitration and read-latency
// tracking in front of the byte-enable dual-port RDM SRAM.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rdm_dpsram_ctrl #(
  parameter int DATA_WIDTH = 1152,
  parameter int ADDR_WIDTH = 11,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  init_done,
  input  logic                  wr0_valid,
  output logic                  wr0_ready,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic [BE_WIDTH-1:0]   wr0_be,
  input  logic                  wr1_valid,
  output logic                  wr1_ready,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  input  logic [BE_WIDTH-1:0]   wr1_be,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [BE_WIDTH-1:0]   ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic                  last_grant;
  logic [2:0]            rd_pipe;
  logic                  accept_en;
  logic                  wr_grant;
  logic [ADDR_WIDTH-1:0] wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Requests arriving alongside clr_start are refused so nothing slips into the clear.
  always_comb begin
    state_next = state;
    accept_en  = 1'b0;
    if (state == ST_INIT) begin
      if (init_ptr == LAST_ROW) begin
        state_next = ST_RUN;
      end
    end else begin
      if (clr_start) begin
        state_next = ST_INIT;
      end else begin
        accept_en = 1'b1;
      end
    end
    wr0_ready = accept_en & wr0_valid & (~wr1_valid | last_grant);
    wr1_ready = accept_en & wr1_valid & (~wr0_valid | ~last_grant);
    wr_grant  = wr0_ready | wr1_ready;
    wr_addr   = wr1_ready ? wr1_addr : wr0_addr;
    rd_ready  = accept_en & ~(wr_grant & (wr_addr == rd_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addra  <= '0;
      ram_dina   <= '0;
      ram_wea    <= '0;
      ram_addrb  <= '0;
      init_done  <= 1'b0;
      init_ptr   <= '0;
      last_grant <= 1'b1;
      rd_pipe    <= '0;
    end else begin
      // The read pipeline keeps running across a clear so in-flight reads complete.
      rd_pipe <= {rd_pipe[1:0], rd_valid & rd_ready};
      if (rd_valid && rd_ready) begin
        ram_addrb <= rd_addr;
      end
      if (state == ST_INIT) begin
        ram_addra <= init_ptr;
        ram_dina  <= '0;
        ram_wea   <= '1;
        init_ptr  <= init_ptr + 1'b1;
        if (init_ptr == LAST_ROW) begin
          init_done <= 1'b1;
        end
      end else begin
        if (clr_start) begin
          init_done <= 1'b0;
        end
        if (wr_grant) begin
          ram_addra  <= wr_addr;
          ram_dina   <= wr1_ready ? wr1_data : wr0_data;
          ram_wea    <= wr1_ready ? wr1_be : wr0_be;
          last_grant <= wr1_ready;
        end else begin
          ram_wea <= '0;
        end
      end
    end
  end

  assign rd_data       = ram_doutb;
  assign rd_data_valid = rd_pipe[2];

endmodule

`default_nettype wire

// File: doc/rdm_dpsram_ctrl.md
Name: rdm_dpsram_ctrl

Overview:
- Single-clock controller in front of the 1152-bit byte-enable dual-port RDM SRAM.
- Zero-fills every row after reset or on request.
- Round-robin arbitrates two byte-enable write requesters onto the SRAM write port.
- Issues single-requester reads, tracks the SRAM's 2-cycle registered read latency and flags returned data with rd_data_valid.

Parameters:
DATA_WIDTH, 1152, SRAM row width in bits; must be a multiple of 8
ADDR_WIDTH, 11, SRAM address width; depth = 2**ADDR_WIDTH
BE_WIDTH, DATA_WIDTH/8 (144), byte-enable width

Ports:
clk  in  1  single clock; also drives SRAM clka and clkb
rst_n  in  1  asynchronous active-low reset
clr_start  in  1  one-cycle pulse: re-zero the whole SRAM
init_done  out  1  high when in RUN
wr0_valid / wr1_valid  in  1  write request
wr0_ready / wr1_ready  out  1  write grant (combinational)
wr0_addr / wr1_addr  in  ADDR_WIDTH  row address
wr0_data / wr1_data  in  DATA_WIDTH  write data
wr0_be / wr1_be  in  BE_WIDTH  byte enables; bit i covers data[8i+7:8i]
rd_valid  in  1  read request
rd_ready  out  1  read grant (combinational)
rd_addr  in  ADDR_WIDTH  read row address
rd_data  out  DATA_WIDTH  = ram_doutb, pass-through
rd_data_valid  out  1  rd_data holds the result of an accepted read
ram_addra  out  ADDR_WIDTH  SRAM write address, registered
ram_dina  out  DATA_WIDTH  SRAM write data, registered
ram_wea  out  BE_WIDTH  SRAM byte write enables, registered
ram_addrb  out  ADDR_WIDTH  SRAM read address, registered
ram_doutb  in  DATA_WIDTH  SRAM read data (2-cycle registered)

Behaviour:
- Reset (async, rst_n=0):
  - Registered outputs clear: ram_addra, ram_dina, ram_wea, ram_addrb, init_done, rd_data_valid pipeline.
  - State = INIT, init_ptr=0, last_grant=1 (wr0 wins first).
  - After rst_n deasserts, initialisation starts automatically.
- FSM: INIT, RUN.
  - INIT:
    - Each cycle drives ram_addra<=init_ptr, ram_dina<=0, ram_wea<=all ones, init_ptr++.
    - When init_ptr==2**ADDR_WIDTH-1 is issued, next state RUN and init_done<=1; init_ptr wraps to 0.
    - Duration 2**ADDR_WIDTH cycles (2048 at default).
    - wr*_ready=0, rd_ready=0; clr_start ignored.
  - RUN:
    - clr_start=1 → INIT next cycle, init_done<=0.
    - Requests presented in that same cycle are not granted: all readys forced 0.
- Write arbitration (RUN only):
  - One valid: grant it.
  - Both valid: grant the one not equal to last_grant; last_grant updates on every grant.
  - Granted at cycle t: ram_addra/ram_dina/ram_wea = request fields at t+1; SRAM row updated at the end of t+1.
  - No grant: ram_wea<=0; ram_addra and ram_dina hold.
  - be==0 is still accepted and consumes the slot; it writes nothing.
- Read (RUN only):
  - rd_ready=1 unless a write is granted this cycle to an address equal to rd_addr (read-after-write hazard stall).
  - Accepted at t: ram_addrb=rd_addr at t+1; rd_data_valid=1 at t+3 with rd_data = row contents.
  - Reads accepted back-to-back give back-to-back rd_data_valid.
  - ram_addrb holds when idle.
  - A read accepted at cycle t+1 or later after a write to the same row returns the new data.
- rd_data_valid pipeline: 3-stage shift of (rd_valid & rd_ready).
  - Keeps shifting through a clr_start transition, so in-flight reads still complete.
  - Data returned may then come from a row mid-clear; that is permitted.
- Reset mid-operation: immediate abort, FSM back to INIT, in-flight reads dropped (rd_data_valid=0).

Test Plan:
1. Release reset → ram_wea all ones for exactly 2048 cycles, ram_addra 0..2047. init_done rises the cycle after addr 2047 is issued. All readys 0 throughout.
2. RUN, wr0 only: addr=5, data byte0=0xAA, be=0x1 → ram_addra=5, ram_wea=0x1 one cycle later. A later read of 5 returns byte0=0xAA, other bytes 0, with rd_data_valid 3 cycles after accept.
3. wr0 and wr1 both valid for 4 cycles, addresses 1..4 each → grant order wr0, wr1, wr0, wr1. Repeat with last_grant=0 → wr1 first.
4. Same-cycle hazard, wr0 addr=9 and rd addr=9 → rd_ready=0 that cycle. Read accepted next cycle returns the new data. rd addr=10 in the same cycle → rd_ready=1.
5. 3 reads accepted back-to-back, then clr_start → 3 rd_data_valid pulses still appear. INIT re-runs for 2048 cycles. A read of addr 5 afterwards returns all zeros.
6. rst_n low for 1 cycle mid-INIT at init_ptr=100 → outputs clear immediately. INIT restarts at addr 0 and takes the full 2048 cycles.
